interseccion_n: RTL

// Parametrised N-approach traffic-light controller; next generation of the two-street calle block.

---
 rtl/interseccion_n.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/interseccion_n.sv
// N-approach round-robin traffic-light controller with per-street green/yellow, all-red clearance,
// a latched pedestrian phase and a night flashing mode. All outputs come straight from registers.
module interseccion_n #(
  parameter int N_CALLES    = 4,
  parameter int T_VERDE     = 8,
  parameter int T_AMARILLO  = 3,
  parameter int T_TODO_ROJO = 1,
  parameter int T_PEATON    = 5,
  parameter int T_PARPADEO  = 2,
  parameter int CNT_W       = 8,
  localparam int IDX_W      = (N_CALLES > 1) ? $clog2(N_CALLES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enb,
  input  logic                  modo_noche,
  input  logic [N_CALLES-1:0]   peatonal,
  output logic [2*N_CALLES-1:0] semaforo,
  output logic [N_CALLES-1:0]   paso_peatonal,
  output logic [IDX_W-1:0]      fase_activa
);

  localparam logic [1:0] L_ROJO     = 2'b00;
  localparam logic [1:0] L_VERDE    = 2'b01;
  localparam logic [1:0] L_AMARILLO = 2'b10;
  localparam logic [1:0] L_APAGADO  = 2'b11;

  localparam logic [CNT_W-1:0] LD_VERDE     = CNT_W'(T_VERDE - 1);
  localparam logic [CNT_W-1:0] LD_AMARILLO  = CNT_W'(T_AMARILLO - 1);
  localparam logic [CNT_W-1:0] LD_TODO_ROJO = CNT_W'(T_TODO_ROJO - 1);
  localparam logic [CNT_W-1:0] LD_PEATON    = CNT_W'(T_PEATON - 1);
  localparam logic [CNT_W-1:0] LD_PARPADEO  = CNT_W'(T_PARPADEO - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_CALLES - 1);

  typedef enum logic [2:0] {
    S_TODO_ROJO,
    S_VERDE,
    S_AMARILLO,
    S_PEATON,
    S_NOCHE
  } estado_t;

  estado_t               state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [N_CALLES-1:0]   pend_reg, pend_next;
  logic [N_CALLES-1:0]   paso_reg, paso_next;
  logic                  blink_reg, blink_next;
  logic                  primero_reg, primero_next;
  logic [2*N_CALLES-1:0] sem_reg, sem_next;
  logic                  cnt_fin;
  logic [IDX_W-1:0]      idx_inc;

  assign cnt_fin = (cnt_reg == '0);
  assign idx_inc = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    pend_next    = pend_reg;
    paso_next    = paso_reg;
    blink_next   = blink_reg;
    primero_next = primero_reg;

    if (enb) begin
      pend_next = pend_reg | peatonal;
      unique case (state_reg)
        S_TODO_ROJO: begin
          if (!cnt_fin) begin
            cnt_next = cnt_reg - 1'b1;
          end else if (modo_noche) begin
            state_next = S_NOCHE;
            cnt_next   = LD_PARPADEO;
            blink_next = 1'b0;
          end else if (|pend_reg) begin
            // Buttons pressed on the entry cycle are served now, not re-latched.
            state_next = S_PEATON;
            cnt_next   = LD_PEATON;
            paso_next  = pend_reg | peatonal;
            pend_next  = '0;
          end else begin
            state_next   = S_VERDE;
            cnt_next     = LD_VERDE;
            idx_next     = primero_reg ? idx_reg : idx_inc;
            primero_next = 1'b0;
          end
        end
        S_VERDE: begin
          if (cnt_fin) begin
            state_next = S_AMARILLO;
            cnt_next   = LD_AMARILLO;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        S_AMARILLO: begin
          if (cnt_fin) begin
            state_next = S_TODO_ROJO;
            cnt_next   = LD_TODO_ROJO;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        S_PEATON: begin
          if (cnt_fin) begin
            state_next   = S_VERDE;
            cnt_next     = LD_VERDE;
            idx_next     = primero_reg ? idx_reg : idx_inc;
            primero_next = 1'b0;
            paso_next    = '0;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        S_NOCHE: begin
          // Leaving night mode restarts the rotation on the same street.
          if (!modo_noche) begin
            state_next   = S_TODO_ROJO;
            cnt_next     = LD_TODO_ROJO;
            blink_next   = 1'b0;
            primero_next = 1'b1;
          end else if (cnt_fin) begin
            cnt_next   = LD_PARPADEO;
            blink_next = ~blink_reg;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        default: begin
          state_next = S_TODO_ROJO;
          cnt_next   = LD_TODO_ROJO;
        end
      endcase
    end
  end

  // Lamps are decoded from the next state so the registered outputs line up with the state register.
  generate
    for (genvar gi = 0; gi < N_CALLES; gi++) begin : g_lamp
      logic es_actual;
      assign es_actual = (idx_next == IDX_W'(gi));
      assign sem_next[2*gi +: 2] =
        (state_next == S_VERDE    && es_actual) ? L_VERDE    :
        (state_next == S_AMARILLO && es_actual) ? L_AMARILLO :
        (state_next == S_NOCHE) ? (blink_next ? L_APAGADO : L_AMARILLO) :
        L_ROJO;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= S_TODO_ROJO;
      cnt_reg     <= LD_TODO_ROJO;
      idx_reg     <= '0;
      pend_reg    <= '0;
      paso_reg    <= '0;
      blink_reg   <= 1'b0;
      primero_reg <= 1'b1;
      sem_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      pend_reg    <= pend_next;
      paso_reg    <= paso_next;
      blink_reg   <= blink_next;
      primero_reg <= primero_next;
      sem_reg     <= sem_next;
    end
  end

  assign semaforo      = sem_reg;
  assign paso_peatonal = paso_reg;
  assign fase_activa   = idx_reg;

endmodule
